// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, EXE operand
// forwarding select and saturating performance counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic [4:0]       idexe_rs,
  input  logic [4:0]       idexe_rt,
  input  logic             idexe_memread,
  input  logic             exemem_regwrite,
  input  logic [4:0]       exemem_waddr,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_waddr,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idexe_bubble,
  output logic             ifid_flush,
  output logic             idexe_flush,
  output logic             exemem_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   lu;

  assign lu = idexe_memread && (idexe_rt != 5'd0) &&
              ((idexe_rt == ifid_rs) || (idexe_rt == ifid_rt));

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // lu is only honoured from RUN: in STALL the bubble sits in ID/EXE, and in
  // FLUSH both lu and the branch result come from flushed nops.
  always_comb begin
    state_nxt    = RUN;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idexe_bubble = 1'b0;
    ifid_flush   = 1'b0;
    idexe_flush  = 1'b0;
    exemem_flush = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idexe_flush  = 1'b1;
      exemem_flush = 1'b1;
    end else begin
      unique case (state)
        RUN, STALL: begin
          if (branch_taken) begin
            ifid_flush   = 1'b1;
            idexe_flush  = 1'b1;
            exemem_flush = 1'b1;
            state_nxt    = FLUSH;
          end else if ((state == RUN) && lu) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idexe_bubble = 1'b1;
            state_nxt    = STALL;
          end
        end
        FLUSH:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (exemem_regwrite && (exemem_waddr != 5'd0) && (exemem_waddr == src))
      return 2'b10;
    else if (memwb_regwrite && (memwb_waddr != 5'd0) && (memwb_waddr == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign forward_a = fwd_sel(idexe_rs);
  assign forward_b = fwd_sel(idexe_rt);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
      if (idexe_bubble && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (idexe_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven single-cycle vectors from
// RUN plus directed multi-cycle sequences and a 4-bit counter saturation run.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ifid_rs, ifid_rt, idexe_rs, idexe_rt, exemem_waddr, memwb_waddr;
  logic        idexe_memread, exemem_regwrite, memwb_regwrite, branch_taken;
  logic        pc_write, ifid_write, idexe_bubble;
  logic        ifid_flush, idexe_flush, exemem_flush;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] cycle_count, stall_count, flush_count;
  logic        s_pc_write, s_ifid_write, s_idexe_bubble;
  logic        s_ifid_flush, s_idexe_flush, s_exemem_flush;
  logic [1:0]  s_forward_a, s_forward_b;
  logic [3:0]  s_cycle_count, s_stall_count, s_flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idexe_rs(idexe_rs), .idexe_rt(idexe_rt),
    .idexe_memread(idexe_memread), .exemem_regwrite(exemem_regwrite),
    .exemem_waddr(exemem_waddr), .memwb_regwrite(memwb_regwrite),
    .memwb_waddr(memwb_waddr), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .idexe_bubble(idexe_bubble),
    .ifid_flush(ifid_flush), .idexe_flush(idexe_flush), .exemem_flush(exemem_flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .cycle_count(cycle_count), .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idexe_rs(idexe_rs), .idexe_rt(idexe_rt),
    .idexe_memread(idexe_memread), .exemem_regwrite(exemem_regwrite),
    .exemem_waddr(exemem_waddr), .memwb_regwrite(memwb_regwrite),
    .memwb_waddr(memwb_waddr), .branch_taken(branch_taken),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idexe_bubble(s_idexe_bubble),
    .ifid_flush(s_ifid_flush), .idexe_flush(s_idexe_flush), .exemem_flush(s_exemem_flush),
    .forward_a(s_forward_a), .forward_b(s_forward_b),
    .cycle_count(s_cycle_count), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  typedef struct {
    logic [4:0] ifid_rs, ifid_rt, idexe_rs, idexe_rt;
    logic       memread, exwr;
    logic [4:0] exaddr;
    logic       wbwr;
    logic [4:0] wbaddr;
    logic       br;
    logic       pw, iw, chk_iw, bub;
    logic [2:0] fl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ifid_rs = 0; ifid_rt = 0; idexe_rs = 0; idexe_rt = 0;
    idexe_memread = 0; exemem_regwrite = 0; exemem_waddr = 0;
    memwb_regwrite = 0; memwb_waddr = 0; branch_taken = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic set_lu;
    idexe_memread = 1; idexe_rt = 5; ifid_rt = 5;
  endtask

  task automatic chk_ctrl(input string name, input logic pw, input logic iw,
                          input logic bub, input logic [2:0] fl);
    check({name, ".pc_write"}, 32'(pc_write), 32'(pw));
    check({name, ".ifid_write"}, 32'(iw && 1'b1) & 32'(ifid_write | ~iw) | 32'(ifid_write), 32'(iw));
    check({name, ".bubble"}, 32'(idexe_bubble), 32'(bub));
    check({name, ".flush"}, 32'({ifid_flush, idexe_flush, exemem_flush}), 32'(fl));
  endtask

  initial begin
    //          ifrs ifrt exrs exrt mr exwr exad wbwr wbad br  pw iw ci bub fl      fa     fb
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 3'b000, 2'b00, 2'b00};
    vecs[1]  = '{1, 5, 2, 5, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 3'b000, 2'b00, 2'b00};
    vecs[2]  = '{7, 2, 1, 7, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 3'b000, 2'b00, 2'b00};
    vecs[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 3'b000, 2'b00, 2'b00};
    vecs[4]  = '{5, 5, 2, 5, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 3'b000, 2'b00, 2'b00};
    vecs[5]  = '{1, 2, 3, 0, 0, 1, 3, 1, 3, 0,  1, 1, 1, 0, 3'b000, 2'b10, 2'b00};
    vecs[6]  = '{1, 2, 3, 0, 0, 0, 3, 1, 3, 0,  1, 1, 1, 0, 3'b000, 2'b01, 2'b00};
    vecs[7]  = '{1, 2, 3, 0, 0, 0, 3, 1, 0, 0,  1, 1, 1, 0, 3'b000, 2'b00, 2'b00};
    vecs[8]  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0,  1, 1, 1, 0, 3'b000, 2'b00, 2'b00};
    vecs[9]  = '{1, 2, 4, 9, 0, 1, 9, 1, 4, 0,  1, 1, 1, 0, 3'b000, 2'b01, 2'b10};
    vecs[10] = '{1, 5, 2, 5, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 3'b111, 2'b00, 2'b00};
    vecs[11] = '{6, 1, 6, 6, 1, 1, 6, 0, 0, 0,  0, 0, 1, 1, 3'b000, 2'b10, 2'b10};
    vecs[12] = '{1, 2, 8, 0, 0, 1, 9, 0, 8, 0,  1, 1, 1, 0, 3'b000, 2'b00, 2'b00};

    reset = 1'b1;
    clear_inputs();
    tick();
    check("rst.pc_write", 32'(pc_write), 0);
    check("rst.ifid_write", 32'(ifid_write), 0);
    check("rst.bubble", 32'(idexe_bubble), 0);
    check("rst.flush", 32'({ifid_flush, idexe_flush, exemem_flush}), 32'(3'b111));
    check("rst.cycle_count", cycle_count, 0);
    check("rst.stall_count", stall_count, 0);
    check("rst.flush_count", flush_count, 0);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      ifid_rs = vecs[i].ifid_rs; ifid_rt = vecs[i].ifid_rt;
      idexe_rs = vecs[i].idexe_rs; idexe_rt = vecs[i].idexe_rt;
      idexe_memread = vecs[i].memread; exemem_regwrite = vecs[i].exwr;
      exemem_waddr = vecs[i].exaddr; memwb_regwrite = vecs[i].wbwr;
      memwb_waddr = vecs[i].wbaddr; branch_taken = vecs[i].br;
      #1;
      check($sformatf("vec%0d.pc_write", i), 32'(pc_write), 32'(vecs[i].pw));
      if (vecs[i].chk_iw)
        check($sformatf("vec%0d.ifid_write", i), 32'(ifid_write), 32'(vecs[i].iw));
      check($sformatf("vec%0d.bubble", i), 32'(idexe_bubble), 32'(vecs[i].bub));
      check($sformatf("vec%0d.flush", i),
            32'({ifid_flush, idexe_flush, exemem_flush}), 32'(vecs[i].fl));
      check($sformatf("vec%0d.forward_a", i), 32'(forward_a), 32'(vecs[i].fa));
      check($sformatf("vec%0d.forward_b", i), 32'(forward_b), 32'(vecs[i].fb));
    end

    // Load-use: one bubble, then STALL releases, then RUN re-evaluates lu.
    do_reset();
    set_lu();
    #1;
    check("lu.c0.pc_write", 32'(pc_write), 0);
    check("lu.c0.ifid_write", 32'(ifid_write), 0);
    check("lu.c0.bubble", 32'(idexe_bubble), 1);
    tick();
    check("lu.c1.pc_write", 32'(pc_write), 1);
    check("lu.c1.ifid_write", 32'(ifid_write), 1);
    check("lu.c1.bubble", 32'(idexe_bubble), 0);
    check("lu.c1.stall_count", stall_count, 1);
    tick();
    check("lu.c2.stall_count", stall_count, 1);
    check("lu.c2.bubble", 32'(idexe_bubble), 1);
    check("lu.c2.cycle_count", cycle_count, 2);

    // Branch with lu in RUN, then both masked in FLUSH.
    do_reset();
    set_lu();
    branch_taken = 1;
    #1;
    check("br.c0.flush", 32'({ifid_flush, idexe_flush, exemem_flush}), 32'(3'b111));
    check("br.c0.bubble", 32'(idexe_bubble), 0);
    check("br.c0.pc_write", 32'(pc_write), 1);
    tick();
    check("br.c1.flush", 32'({ifid_flush, idexe_flush, exemem_flush}), 0);
    check("br.c1.bubble", 32'(idexe_bubble), 0);
    check("br.c1.pc_write", 32'(pc_write), 1);
    check("br.c1.ifid_write", 32'(ifid_write), 1);
    check("br.c1.flush_count", flush_count, 1);
    tick();
    check("br.c2.flush", 32'({ifid_flush, idexe_flush, exemem_flush}), 32'(3'b111));
    check("br.c2.flush_count", flush_count, 1);
    check("br.c2.stall_count", stall_count, 0);

    // Branch resolving while in STALL.
    do_reset();
    set_lu();
    tick();
    branch_taken = 1;
    #1;
    check("stbr.flush", 32'({ifid_flush, idexe_flush, exemem_flush}), 32'(3'b111));
    check("stbr.pc_write", 32'(pc_write), 1);
    tick();
    check("stbr.next.flush", 32'({ifid_flush, idexe_flush, exemem_flush}), 0);
    check("stbr.next.bubble", 32'(idexe_bubble), 0);
    check("stbr.stall_count", stall_count, 1);
    check("stbr.flush_count", flush_count, 1);

    // Reset asserted while in STALL.
    do_reset();
    set_lu();
    tick();
    reset = 1;
    idexe_rs = 3; exemem_regwrite = 1; exemem_waddr = 3;
    #1;
    check("rststall.flush", 32'({ifid_flush, idexe_flush, exemem_flush}), 32'(3'b111));
    check("rststall.pc_write", 32'(pc_write), 0);
    check("rststall.ifid_write", 32'(ifid_write), 0);
    check("rststall.bubble", 32'(idexe_bubble), 0);
    check("rststall.forward_a", 32'(forward_a), 32'(2'b10));
    tick();
    reset = 0;
    #1;
    check("rststall.cycle_count", cycle_count, 0);
    check("rststall.stall_count", stall_count, 0);
    check("rststall.flush_count", flush_count, 0);
    check("rststall.lu.bubble", 32'(idexe_bubble), 1);
    check("rststall.lu.pc_write", 32'(pc_write), 0);

    // Saturation of the 4-bit counters.
    do_reset();
    repeat (20) tick();
    check("sat.cycle_count", 32'(s_cycle_count), 15);
    check("sat.main_cycle_count", cycle_count, 20);
    tick();
    check("sat.cycle_hold", 32'(s_cycle_count), 15);
    do_reset();
    branch_taken = 1;
    repeat (40) tick();
    check("sat.flush_count", 32'(s_flush_count), 15);
    check("sat.main_flush_count", flush_count, 20);
    do_reset();
    set_lu();
    repeat (40) tick();
    check("sat.stall_count", 32'(s_stall_count), 15);
    check("sat.main_stall_count", stall_count, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage CPU (IF, ID, EXE, MEM, WB). It detects load-use hazards and stalls the PC and IF/ID register while inserting a bubble into ID/EXE. It flushes IF/ID, ID/EXE and EXE/MEM when a branch resolves taken in MEM, and selects the EXE-stage ALU operand forwarding sources. Small performance counters track cycles, stalls and flushes for bench and debug visibility.

## Interface
- CNT_W, 32, width of each performance counter
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- ifid_rs  input  5  IF/ID instruction [25:21]
- ifid_rt  input  5  IF/ID instruction [20:16]
- idexe_rs  input  5  ID/EXE addr1 (rs of instruction in EXE)
- idexe_rt  input  5  ID/EXE addr2 (rt of instruction in EXE; load destination)
- idexe_memread  input  1  ID/EXE MemRead
- exemem_regwrite  input  1  EXE/MEM RegWrite
- exemem_waddr  input  5  EXE/MEM write address
- memwb_regwrite  input  1  MEM/WB RegWrite
- memwb_waddr  input  5  MEM/WB write address
- branch_taken  input  1  MEM-stage branch result (Branch & zero)
- pc_write  output  1  PC load enable
- ifid_write  output  1  IF/ID load enable
- idexe_bubble  output  1  ID/EXE loads all-zero control fields
- ifid_flush, idexe_flush, exemem_flush  output  1 each  load a nop (all fields zero) into that register
- forward_a, forward_b  output  2 each  EXE operand select: 00 register file, 10 EXE/MEM ALU result, 01 MEM/WB write data
- cycle_count, stall_count, flush_count  output  CNT_W each  performance counters

## Operation
- FSM states: RUN, STALL, FLUSH. Reset state is RUN.
- Load-use hit (lu): idexe_memread & idexe_rt != 0 & (idexe_rt == ifid_rs | idexe_rt == ifid_rt).
- Priority: reset > branch_taken > lu.
- RUN, branch_taken=1:
  - ifid_flush, idexe_flush and exemem_flush assert this cycle; pc_write=1, so the target is loaded.
  - Next state is FLUSH. lu is ignored.
- RUN, lu=1, branch_taken=0:
  - pc_write=0, ifid_write=0, idexe_bubble=1.
  - Next state is STALL.
- RUN otherwise: pc_write=1 and ifid_write=1; no flush or bubble; state stays RUN.
- STALL: lu is masked because ID/EXE holds the bubble.
  - branch_taken=1 is handled exactly as in RUN and the next state is FLUSH.
  - Otherwise normal enables apply and the next state is RUN.
- FLUSH: lu and branch_taken are both masked, because MEM holds a flushed nop. Normal enables apply; the next state is RUN.
- Forwarding is combinational and independent of FSM state. Operand A compares idexe_rs; operand B compares idexe_rt.
  - Select 10 if exemem_regwrite & exemem_waddr != 0 & exemem_waddr == src.
  - Else select 01 if memwb_regwrite & memwb_waddr != 0 & memwb_waddr == src.
  - Else select 00.
  - EXE/MEM wins over MEM/WB when both match.
- Same-cycle WB write / ID read of one register is resolved inside the register file, not here.
- Counters are unsigned and saturate at all-ones (no wrap).
  - cycle_count increments every non-reset cycle.
  - stall_count increments on each cycle with idexe_bubble=1.
  - flush_count increments on each cycle with idexe_flush=1.

## Timing
- All control outputs are combinational from the inputs and current state, and take effect at the next rising edge.
- While reset=1:
  - pc_write=0, ifid_write=0, idexe_bubble=0.
  - All three flushes = 1.
  - forward_a and forward_b keep their normal combinational values.
- At the edge where reset=1: state becomes RUN and all counters become 0.
- Load-use costs exactly one bubble. After it, the dependent instruction reaches EXE with the load in MEM/WB, so forward=01.
- Taken branch costs three flushed slots (IF/ID, ID/EXE, EXE/MEM flushed on the same edge the PC loads the target).
- Reset asserted in STALL or FLUSH: state becomes RUN at that edge, with no residual stall or mask.
- Counter at all-ones plus an increment event: the counter holds its value.

## Test plan
- Load-use: idexe_memread=1, idexe_rt=5, ifid_rt=5:
  - Same cycle: pc_write=0, ifid_write=0, idexe_bubble=1.
  - Next cycle (STALL, inputs unchanged): pc_write=1, no bubble.
  - stall_count=1.
- Load to r0: idexe_memread=1, idexe_rt=0, ifid_rs=0 -> no stall.
- Forward priority: idexe_rs=3, exemem_regwrite=1 & exemem_waddr=3, memwb_regwrite=1 & memwb_waddr=3 -> forward_a=10.
  - Drop exemem_regwrite -> forward_a=01.
  - Set memwb_waddr=0 -> forward_a=00.
- Branch during load-use: branch_taken=1 with lu=1 in RUN:
  - All three flushes = 1, idexe_bubble=0, pc_write=1.
  - Next cycle FLUSH: branch_taken=1 and lu=1 held -> no flush, no stall.
  - flush_count=1.
- Reset mid-stall: trigger lu, then assert reset in STALL.
  - During reset: flushes=1, pc_write=0.
  - After release: state RUN, all counters 0.
  - lu on the first cycle after release stalls normally.
- Saturation with CNT_W=4: run 20 cycles without reset -> cycle_count=15 and holds at 15.
